// File: rtl/tsp_pkg.sv
// Shared definitions for the TSP solver datapath: default widths, controller
// state encoding and the saturating adder used by the tour-length accumulator.
package tsp_pkg;

    localparam int IDX_W   = 6;
    localparam int COORD_W = 32;
    localparam int ACC_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_e;

    // Adds two zero-extended operands and clamps to 2^w-1; bit 64 flags the clamp.
    function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = 65'd1 << w;
        if (sum >= lim) begin
            return {1'b1, lim[63:0] - 64'd1};
        end
        return {1'b0, sum[63:0]};
    endfunction

endpackage

// File: rtl/sat_accum.sv
// Saturating accumulator with sticky overflow flag. value/sat present the
// result including this cycle's clear/enable, so a final add is visible at once.
module sat_accum #(
    parameter int W  = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          enable,
    input  logic [AW-1:0] addend,
    output logic [W-1:0]  value,
    output logic          sat
);
    import tsp_pkg::sat_add;

    logic [W-1:0] value_q, value_d;
    logic         sat_q, sat_d;
    logic [64:0]  sum;

    always_comb begin
        sum     = sat_add(64'(value_q), 64'(addend), W);
        value_d = value_q;
        sat_d   = sat_q;
        if (clear) begin
            value_d = '0;
            sat_d   = 1'b0;
        end else if (enable) begin
            value_d = sum[W-1:0];
            sat_d   = sat_q | sum[64] | (|(sum[63:0] >> W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            value_q <= value_d;
            sat_q   <= sat_d;
        end
    end

    assign value = value_d;
    assign sat   = sat_d;

endmodule

// File: rtl/tour_length_ctrl.sv
// Closed-tour length sequencer: streams consecutive city pairs (including the
// wrap-around edge) from the tour RAM into the external distance unit and sums them.
module tour_length_ctrl #(
    parameter int IDX_W   = tsp_pkg::IDX_W,
    parameter int COORD_W = tsp_pkg::COORD_W,
    parameter int ACC_W   = tsp_pkg::ACC_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W:0]     n_cities,
    output logic [IDX_W-1:0]   mem_addr,
    output logic               mem_ren,
    input  logic [COORD_W-1:0] mem_x,
    input  logic [COORD_W-1:0] mem_y,
    output logic [COORD_W-1:0] dist_x1,
    output logic [COORD_W-1:0] dist_y1,
    output logic [COORD_W-1:0] dist_x2,
    output logic [COORD_W-1:0] dist_y2,
    input  logic [COORD_W-1:0] dist_res,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   total,
    output logic               sat
);
    import tsp_pkg::state_e;
    import tsp_pkg::S_IDLE;
    import tsp_pkg::S_READ;
    import tsp_pkg::S_DRAIN;
    import tsp_pkg::S_FIN;

    localparam logic [IDX_W:0] N_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [IDX_W:0] N_MIN = {{(IDX_W-1){1'b0}}, 2'b10};
    localparam logic [IDX_W:0] ONE   = {{IDX_W{1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [IDX_W:0]     n_q, n_d, cnt_q, cnt_d, n_clamp;
    logic               first_q, first_d, rvld_q, rvld_d;
    logic [COORD_W-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
    logic [COORD_W-1:0] p_x_q, p_x_d, p_y_q, p_y_d;
    logic [ACC_W-1:0]   total_q, total_d, acc_value;
    logic               sat_q, sat_d, acc_sat;
    logic               acc_clear, add_en;

    assign n_clamp = (n_cities > N_MAX) ? N_MAX : n_cities;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        rvld_d    = 1'b0;
        prev_x_d  = prev_x_q;
        prev_y_d  = prev_y_q;
        p_x_d     = p_x_q;
        p_y_d     = p_y_q;
        total_d   = total_q;
        sat_d     = sat_q;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        acc_clear = 1'b0;
        add_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_clamp >= N_MIN) begin
                        n_d       = n_clamp;
                        cnt_d     = '0;
                        first_d   = 1'b1;
                        acc_clear = 1'b1;
                        state_d   = S_READ;
                    end else begin
                        total_d = '0;
                        sat_d   = 1'b0;
                        state_d = S_FIN;
                    end
                end
            end
            S_READ: begin
                // Issues addresses 0..n-1 and then 0 once more to close the tour.
                mem_ren = 1'b1;
                rvld_d  = 1'b1;
                if (cnt_q == n_q) begin
                    state_d = S_DRAIN;
                end else begin
                    mem_addr = cnt_q[IDX_W-1:0];
                    cnt_d    = cnt_q + ONE;
                end
            end
            S_DRAIN: begin
                total_d = acc_value;
                sat_d   = acc_sat;
                state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (rvld_q) begin
            prev_x_d = mem_x;
            prev_y_d = mem_y;
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                add_en = 1'b1;
                p_x_d  = mem_x;
                p_y_d  = mem_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            rvld_q   <= 1'b0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            p_x_q    <= '0;
            p_y_q    <= '0;
            total_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            rvld_q   <= rvld_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            p_x_q    <= p_x_d;
            p_y_q    <= p_y_d;
            total_q  <= total_d;
            sat_q    <= sat_d;
        end
    end

    sat_accum #(
        .W  (ACC_W),
        .AW (COORD_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .enable (add_en),
        .addend (dist_res),
        .value  (acc_value),
        .sat    (acc_sat)
    );

    // Second operand follows the RAM output only while an edge is being added.
    assign dist_x1 = prev_x_q;
    assign dist_y1 = prev_y_q;
    assign dist_x2 = add_en ? mem_x : p_x_q;
    assign dist_y2 = add_en ? mem_y : p_y_q;
    assign busy    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done    = (state_q == S_FIN);
    assign total   = total_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_tour_length_ctrl.sv
// Bench for tour_length_ctrl with a synchronous tour RAM and an exact
// integer-sqrt distance stub; expected totals queue up at start, pop at done.
module tb_tour_length_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [6:0]  n_cities;
    logic [5:0]  mem_addr;
    logic        mem_ren;
    logic [31:0] mem_x = '0, mem_y = '0;
    logic [31:0] dist_x1, dist_y1, dist_x2, dist_y2, dist_res;
    logic        busy, done, sat;
    logic [31:0] total;

    logic [31:0] ram_x [64];
    logic [31:0] ram_y [64];
    logic        force_en;
    logic [31:0] force_val;

    logic [31:0] exp_tot_q [$];
    logic        exp_sat_q [$];
    int          n_chk = 0;
    int          n_pass = 0;

    tour_length_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .n_cities(n_cities),
        .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_x(mem_x), .mem_y(mem_y),
        .dist_x1(dist_x1), .dist_y1(dist_y1), .dist_x2(dist_x2), .dist_y2(dist_y2),
        .dist_res(dist_res), .busy(busy), .done(done), .total(total), .sat(sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ren) begin
            mem_x <= ram_x[mem_addr];
            mem_y <= ram_y[mem_addr];
        end
    end

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r, t;
        r = 0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= v) r = t;
        end
        return r;
    endfunction

    function automatic logic [31:0] dist_fn(input logic [31:0] x1, y1, x2, y2);
        longint unsigned dx, dy;
        dx = (x1 > x2) ? 64'(x1 - x2) : 64'(x2 - x1);
        dy = (y1 > y2) ? 64'(y1 - y2) : 64'(y2 - y1);
        return 32'(isqrt(dx * dx + dy * dy));
    endfunction

    assign dist_res = force_en ? force_val : dist_fn(dist_x1, dist_y1, dist_x2, dist_y2);

    function automatic void model(input int n, output logic [31:0] tot, output logic s);
        longint unsigned acc, d;
        int nc, j;
        acc = 0;
        s = 1'b0;
        nc = (n > 64) ? 64 : n;
        if (nc >= 2) begin
            for (int i = 0; i < nc; i++) begin
                j = (i + 1) % nc;
                d = force_en ? 64'(force_val) : 64'(dist_fn(ram_x[i], ram_y[i], ram_x[j], ram_y[j]));
                acc = acc + d;
                if (acc > 64'hFFFF_FFFF) begin
                    acc = 64'hFFFF_FFFF;
                    s = 1'b1;
                end
            end
        end
        tot = acc[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_run(input int n, input string tag, input int glitch_k, input bit start_at_done);
        logic [31:0] et, prev_total, got_tot;
        logic        es, got_sat;
        logic [5:0]  addrs [$];
        int          nc, exp_done, exp_ren, done_k;
        bit          busy_ok, addr_ok;
        model(n, et, es);
        exp_tot_q.push_back(et);
        exp_sat_q.push_back(es);
        nc = (n > 64) ? 64 : n;
        exp_done = (nc < 2) ? 1 : nc + 3;
        exp_ren  = (nc < 2) ? 0 : nc + 1;
        prev_total = total;
        busy_ok = 1'b1;
        done_k = -1;
        n_cities = 7'(n);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k == glitch_k) begin
                start = 1'b1;
                n_cities = 7'd2;
            end else begin
                start = 1'b0;
            end
            if (mem_ren) addrs.push_back(mem_addr);
            if (k == 1 && nc >= 2) chk({tag, "_total_hold"}, total, prev_total);
            if (done) begin
                done_k = k;
                break;
            end
            if (busy !== (nc >= 2)) busy_ok = 1'b0;
            step();
        end
        start = 1'b0;
        got_tot = exp_tot_q.pop_front();
        got_sat = exp_sat_q.pop_front();
        chk({tag, "_done_cycle"}, done_k, exp_done);
        chk({tag, "_busy_window"}, busy_ok, 1'b1);
        chk({tag, "_busy_at_done"}, busy, 1'b0);
        chk({tag, "_total"}, total, got_tot);
        chk({tag, "_sat"}, sat, got_sat);
        chk({tag, "_ren_count"}, addrs.size(), exp_ren);
        addr_ok = (addrs.size() == exp_ren);
        for (int i = 0; i < addrs.size() && i < exp_ren; i++) begin
            if (addrs[i] !== ((i < nc) ? 6'(i) : 6'd0)) addr_ok = 1'b0;
        end
        chk({tag, "_addr_seq"}, addr_ok, 1'b1);
        if (start_at_done) begin
            start = 1'b1;
            n_cities = 7'd4;
        end
        step();
        start = 1'b0;
        chk({tag, "_done_one_cycle"}, done, 1'b0);
        if (start_at_done) chk({tag, "_fin_start_ignored"}, busy, 1'b0);
    endtask

    initial begin
        bit seen;
        rst = 1'b1;
        start = 1'b0;
        n_cities = '0;
        force_en = 1'b0;
        force_val = '0;
        for (int i = 0; i < 64; i++) begin
            ram_x[i] = '0;
            ram_y[i] = '0;
        end
        step();
        step();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_total", total, 32'd0);
        chk("reset_sat", sat, 1'b0);
        chk("reset_ren", mem_ren, 1'b0);
        chk("reset_dist_x1", dist_x1, 32'd0);
        chk("reset_dist_x2", dist_x2, 32'd0);
        rst = 1'b0;
        step();

        ram_x[0] = 0; ram_y[0] = 0; ram_x[1] = 3; ram_y[1] = 4;
        do_run(2, "n2_345", 0, 1'b0);

        ram_x[0] = 0; ram_y[0] = 0; ram_x[1] = 3; ram_y[1] = 0;
        ram_x[2] = 3; ram_y[2] = 4; ram_x[3] = 0; ram_y[3] = 4;
        do_run(4, "n4_rect_glitch", 2, 1'b0);

        ram_x[0] = 0; ram_y[0] = 0; ram_x[1] = 640; ram_y[1] = 480;
        do_run(2, "n2_vga_a", 0, 1'b0);
        do_run(2, "n2_vga_b", 0, 1'b0);

        force_en = 1'b1;
        force_val = 32'hFFFF_FFF0;
        do_run(3, "n3_sat", 0, 1'b0);
        force_en = 1'b0;

        do_run(0, "n0", 0, 1'b0);
        do_run(1, "n1", 0, 1'b0);

        for (int i = 0; i < 64; i++) begin
            ram_x[i] = $urandom_range(0, 1000);
            ram_y[i] = $urandom_range(0, 1000);
        end
        do_run(5, "n5_fin_start", 0, 1'b1);
        do_run(100, "n100_clamp", 0, 1'b0);

        ram_x[0] = 0; ram_y[0] = 0; ram_x[1] = 3; ram_y[1] = 0;
        ram_x[2] = 3; ram_y[2] = 4; ram_x[3] = 0; ram_y[3] = 4;
        n_cities = 7'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_total", total, 32'd0);
        chk("midrst_sat", sat, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy || mem_ren) seen = 1'b1;
            step();
        end
        chk("midrst_quiet", seen, 1'b0);
        chk("scoreboard_empty", exp_tot_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
